uart_tx: RTL

- 8N1/8N2 UART transmitter, the transmit half paired with the existing UART receiver in the same design.
- Accepts bytes from the core over a write-strobe interface into a one-entry holding register.
- Serialises each byte LSB-first onto o_tx with start and stop bits.
- The holding register lets the next byte be queued while the current frame shifts, giving back-to-back frames with no idle gap.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_cnt.sv | 36 +++
 rtl/uart_tx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame constants used by
// both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_e;

    localparam int   DATA_BITS  = 8;
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Width of a counter that must hold values 0..div, never narrower than 1 bit.
    function automatic int cnt_width(input int div);
        return ($clog2(div + 1) < 1) ? 1 : $clog2(div + 1);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 1..BAUD_DIV while enabled, wraps to 1, and
// flags the terminal (last) cycle of each bit period.
module uart_baud_cnt import uart_pkg::*; #(
    parameter int BAUD_DIV = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = cnt_width(BAUD_DIV);

    logic [CW-1:0] r_cnt;
    logic          w_tick;

    assign w_tick = (r_cnt == CW'(BAUD_DIV));
    assign o_tick = w_tick;

    // Clear loads 1 so the cycle after a clear is already the first cycle of a bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= CW'(1);
        end else if (i_en) begin
            if (w_tick) begin
                r_cnt <= CW'(1);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with a one-entry holding register so the next
// byte can be queued while the current frame shifts out.
module uart_tx import uart_pkg::*; #(
    parameter int BAUD_DIV  = 16,
    parameter int STOP_BITS = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_wr,
    output logic       o_tx,
    output logic       o_full,
    output logic       o_busy,
    output logic       o_done
);

    uart_state_e r_state;
    uart_state_e w_state_next;

    logic                 r_tx;
    logic                 r_full;
    logic [DATA_BITS-1:0] r_hold;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit_cnt;

    logic w_tx_next;
    logic w_tick;
    logic w_busy;
    logic w_load;
    logic w_done;
    logic w_shift_en;
    logic w_bit_inc;
    logic w_bit_clr;
    logic w_bit_last;
    logic w_stop_last;

    assign w_busy      = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP);
    assign w_bit_last  = (r_bit_cnt == 3'(DATA_BITS - 1));
    assign w_stop_last = (r_bit_cnt == 3'(STOP_BITS - 1));

    uart_baud_cnt #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_busy),
        .i_clr  (w_load),
        .o_tick (w_tick)
    );

    // The bit counter indexes data bits in DATA and stop bits in STOP.
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx;
        w_load       = 1'b0;
        w_done       = 1'b0;
        w_shift_en   = 1'b0;
        w_bit_inc    = 1'b0;
        w_bit_clr    = 1'b0;
        case (r_state)
            ST_RESET: begin
                w_state_next = ST_IDLE;
                w_tx_next    = LINE_IDLE;
            end
            ST_IDLE: begin
                w_tx_next = LINE_IDLE;
                if (r_full) begin
                    w_load       = 1'b1;
                    w_state_next = ST_START;
                    w_tx_next    = LINE_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next = ST_DATA;
                    w_tx_next    = r_shift[0];
                    w_bit_clr    = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (w_bit_last) begin
                        w_state_next = ST_STOP;
                        w_tx_next    = LINE_IDLE;
                        w_bit_clr    = 1'b1;
                    end else begin
                        w_shift_en = 1'b1;
                        w_bit_inc  = 1'b1;
                        w_tx_next  = r_shift[1];
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (w_stop_last) begin
                        w_done    = 1'b1;
                        w_bit_clr = 1'b1;
                        if (r_full) begin
                            w_load       = 1'b1;
                            w_state_next = ST_START;
                            w_tx_next    = LINE_START;
                        end else begin
                            w_state_next = ST_IDLE;
                            w_tx_next    = LINE_IDLE;
                        end
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_RESET;
                w_tx_next    = LINE_IDLE;
            end
        endcase
    end

    // A load only happens with r_full set, and a write only with r_full clear,
    // so the two never compete for the holding register in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_RESET;
            r_tx      <= LINE_IDLE;
            r_full    <= 1'b0;
            r_hold    <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            if (w_load) begin
                r_shift <= r_hold;
            end else if (w_shift_en) begin
                r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
            end
            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_load) begin
                r_full <= 1'b0;
            end else if (i_wr && !r_full) begin
                r_full <= 1'b1;
                r_hold <= i_data;
            end
        end
    end

    assign o_tx   = r_tx;
    assign o_full = r_full;
    assign o_busy = w_busy;
    assign o_done = w_done;

endmodule
